// File: rtl/insn_sequencer.sv
// Instruction sequencer: fetches from ROM, executes and waits on data memory.
// It also tracks the pc and the compare flag used by conditional branches.
module insn_sequencer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  romReady,
  input  logic                  memReady,
  input  logic                  halt,
  input  logic                  branch,
  input  logic                  jump,
  input  logic                  relative,
  input  logic                  regWrite,
  input  logic                  memoryRead,
  input  logic                  memoryWrite,
  input  logic                  compare,
  input  logic [DATA_WIDTH-1:0] destBranchJump,
  input  logic                  compareIn,
  output logic [DATA_WIDTH-1:0] pc,
  output logic                  romRequest,
  output logic                  insnLoad,
  output logic                  regWriteEn,
  output logic                  memReadEn,
  output logic                  memWriteEn,
  output logic                  busy,
  output logic                  halted
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    EXECUTE = 3'd2,
    MEMORY  = 3'd3,
    HALTED  = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic                  cmp_flag_q, cmp_flag_d;

  logic [DATA_WIDTH-1:0] pc_inc;
  logic [DATA_WIDTH-1:0] pc_target;
  logic [DATA_WIDTH-1:0] pc_next;

  // Branch condition uses the flag as it stood before this instruction.
  always_comb begin
    pc_inc    = pc_q + DATA_WIDTH'(1);
    pc_target = relative ? (pc_q + destBranchJump) : destBranchJump;
    pc_next   = (jump || (branch && cmp_flag_q)) ? pc_target : pc_inc;
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cmp_flag_d = cmp_flag_q;
    romRequest = 1'b0;
    insnLoad   = 1'b0;
    regWriteEn = 1'b0;
    memReadEn  = 1'b0;
    memWriteEn = 1'b0;
    busy       = 1'b0;
    halted     = 1'b0;

    if (reset) begin
      // Reset also masks any strobe that would otherwise fire this cycle.
      state_d    = IDLE;
      pc_d       = '0;
      cmp_flag_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) state_d = FETCH;
        end
        FETCH: begin
          busy       = 1'b1;
          romRequest = 1'b1;
          if (romReady) begin
            insnLoad = 1'b1;
            state_d  = EXECUTE;
          end
        end
        EXECUTE: begin
          busy = 1'b1;
          if (halt) begin
            state_d = HALTED;
          end else if (memoryRead || memoryWrite) begin
            state_d = MEMORY;
          end else begin
            regWriteEn = regWrite;
            if (compare) cmp_flag_d = compareIn;
            pc_d    = pc_next;
            state_d = FETCH;
          end
        end
        MEMORY: begin
          busy       = 1'b1;
          memWriteEn = memoryWrite;
          memReadEn  = memoryRead && !memoryWrite;
          if (memReady) begin
            regWriteEn = regWrite;
            pc_d       = pc_inc;
            state_d    = FETCH;
          end
        end
        HALTED: begin
          halted = 1'b1;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    state_q    <= state_d;
    pc_q       <= pc_d;
    cmp_flag_q <= cmp_flag_d;
  end

  assign pc = pc_q;

endmodule

// File: tb/tb_insn_sequencer.sv
// Directed bench for insn_sequencer at DATA_WIDTH=8; inputs change 1ns after
// the rising edge and outputs are checked after a further settle delay.
module tb_insn_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, romReady, memReady;
  logic       halt, branch, jump, relative, regWrite, memoryRead, memoryWrite, compare;
  logic [7:0] destBranchJump;
  logic       compareIn;
  logic [7:0] pc;
  logic       romRequest, insnLoad, regWriteEn, memReadEn, memWriteEn, busy, halted;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  insn_sequencer #(.DATA_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .romReady(romReady), .memReady(memReady),
    .halt(halt), .branch(branch), .jump(jump), .relative(relative), .regWrite(regWrite),
    .memoryRead(memoryRead), .memoryWrite(memoryWrite), .compare(compare),
    .destBranchJump(destBranchJump), .compareIn(compareIn), .pc(pc),
    .romRequest(romRequest), .insnLoad(insnLoad), .regWriteEn(regWriteEn),
    .memReadEn(memReadEn), .memWriteEn(memWriteEn), .busy(busy), .halted(halted)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic set_ctrl(input logic h, input logic b, input logic j, input logic r,
                          input logic rw, input logic mr, input logic mw, input logic c,
                          input logic [7:0] d, input logic ci);
    halt = h; branch = b; jump = j; relative = r; regWrite = rw;
    memoryRead = mr; memoryWrite = mw; compare = c; destBranchJump = d; compareIn = ci;
  endtask

  // From FETCH: one fetch cycle plus one execute cycle.
  task automatic run_insn;
    romReady = 1'b1;
    tick();
    romReady = 1'b0;
    tick();
  endtask

  task automatic jump_to(input logic [7:0] addr);
    set_ctrl(0, 0, 1, 0, 0, 0, 0, 0, addr, 0);
    run_insn();
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_romreq"}, romRequest, 0);
    check({tag, "_ld"},     insnLoad,   0);
    check({tag, "_rwe"},    regWriteEn, 0);
    check({tag, "_mre"},    memReadEn,  0);
    check({tag, "_mwe"},    memWriteEn, 0);
    check({tag, "_busy"},   busy,       0);
    check({tag, "_halted"}, halted,     0);
  endtask

  initial begin
    #20000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; start = 1'b0; romReady = 1'b0; memReady = 1'b0;
    set_ctrl(0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0);
    tick(); tick();
    check("rst_pc", pc, 8'h00);
    check_quiet("rst");
    reset = 1'b0;
    settle();
    check("idle_busy", busy, 0);

    // First ALU instruction
    start = 1'b1;
    tick();
    start = 1'b0;
    settle();
    check("fetch_romreq", romRequest, 1);
    check("fetch_busy", busy, 1);
    set_ctrl(0, 0, 0, 0, 1, 0, 0, 0, 8'h00, 0);
    tick();
    check("fetch_wait_ld", insnLoad, 0);
    check("fetch_wait_pc", pc, 8'h00);
    romReady = 1'b1;
    settle();
    check("fetch_ld", insnLoad, 1);
    check("fetch_rwe", regWriteEn, 0);
    tick();
    romReady = 1'b0;
    settle();
    check("exec_ld", insnLoad, 0);
    check("exec_rwe", regWriteEn, 1);
    check("exec_romreq", romRequest, 0);
    check("exec_pc", pc, 8'h00);
    tick();
    check("alu_pc", pc, 8'h01);
    check("alu_rwe_off", regWriteEn, 0);
    check("alu_back_fetch", romRequest, 1);

    // Jumps
    jump_to(8'h05);
    check("jabs5_pc", pc, 8'h05);
    set_ctrl(0, 0, 1, 1, 0, 0, 0, 0, 8'hFE, 0);
    run_insn();
    check("jrel_pc", pc, 8'h03);
    jump_to(8'h10);
    check("jabs10_pc", pc, 8'h10);

    // Branches
    jump_to(8'h07);
    set_ctrl(0, 1, 0, 0, 0, 0, 0, 0, 8'h20, 0);
    run_insn();
    check("br_nt_pc", pc, 8'h08);
    set_ctrl(0, 0, 0, 0, 0, 0, 0, 1, 8'h00, 1);
    run_insn();
    check("cmp_pc", pc, 8'h09);
    set_ctrl(0, 1, 0, 0, 0, 0, 0, 0, 8'h20, 0);
    run_insn();
    check("br_t_pc", pc, 8'h20);

    // Load with memReady on the third memory cycle
    set_ctrl(0, 0, 0, 0, 1, 1, 0, 0, 8'h00, 0);
    romReady = 1'b1;
    tick();
    romReady = 1'b0;
    settle();
    check("ld_exec_rwe", regWriteEn, 0);
    check("ld_exec_mre", memReadEn, 0);
    tick();
    romReady = 1'b1;
    settle();
    check("ld_m1_mre", memReadEn, 1);
    check("ld_m1_mwe", memWriteEn, 0);
    check("ld_m1_rwe", regWriteEn, 0);
    check("ld_m1_ld", insnLoad, 0);
    tick();
    romReady = 1'b0;
    settle();
    check("ld_m2_mre", memReadEn, 1);
    check("ld_m2_rwe", regWriteEn, 0);
    check("ld_m2_pc", pc, 8'h20);
    tick();
    memReady = 1'b1;
    settle();
    check("ld_m3_mre", memReadEn, 1);
    check("ld_m3_rwe", regWriteEn, 1);
    tick();
    memReady = 1'b0;
    settle();
    check("ld_done_pc", pc, 8'h21);
    check("ld_done_mre", memReadEn, 0);
    check("ld_done_rwe", regWriteEn, 0);
    check("ld_done_fetch", romRequest, 1);

    // Read and write both set: write wins
    set_ctrl(0, 0, 0, 0, 1, 1, 1, 0, 8'h00, 0);
    run_insn();
    memReady = 1'b1;
    settle();
    check("rw_mwe", memWriteEn, 1);
    check("rw_mre", memReadEn, 0);
    tick();
    memReady = 1'b0;
    check("rw_pc", pc, 8'h22);

    // Halt has priority over the other decoded inputs
    jump_to(8'h0A);
    set_ctrl(1, 1, 1, 0, 1, 1, 1, 1, 8'h55, 1);
    romReady = 1'b1;
    tick();
    romReady = 1'b0;
    settle();
    check("halt_exec_rwe", regWriteEn, 0);
    check("halt_exec_mre", memReadEn, 0);
    check("halt_exec_mwe", memWriteEn, 0);
    tick();
    check("halt_halted", halted, 1);
    check("halt_busy", busy, 0);
    check("halt_pc", pc, 8'h0A);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("halt_start_ign", halted, 1);
    check("halt_start_pc", pc, 8'h0A);
    check("halt_romreq", romRequest, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    settle();
    check("unhalt_pc", pc, 8'h00);
    check_quiet("unhalt");

    // Reset in the middle of a memory wait, same cycle as memReady
    start = 1'b1;
    tick();
    start = 1'b0;
    jump_to(8'h30);
    set_ctrl(0, 0, 0, 0, 1, 1, 0, 0, 8'h00, 0);
    run_insn();
    settle();
    check("mrst_pre_mre", memReadEn, 1);
    memReady = 1'b1;
    reset = 1'b1;
    settle();
    check("mrst_same_rwe", regWriteEn, 0);
    tick();
    memReady = 1'b0;
    reset = 1'b0;
    settle();
    check("mrst_pc", pc, 8'h00);
    check_quiet("mrst");
    tick();
    check("mrst_idle_pc", pc, 8'h00);
    check("mrst_idle_busy", busy, 0);

    // pc wraps from 0xFF
    start = 1'b1;
    tick();
    start = 1'b0;
    jump_to(8'hFF);
    check("wrap_pre_pc", pc, 8'hFF);
    set_ctrl(0, 0, 0, 0, 1, 0, 0, 0, 8'h00, 0);
    run_insn();
    check("wrap_pc", pc, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
